md5_crack_ctrl: RTL

MD5_CRACK_CTRL -- requirements
Module: md5_crack_ctrl

---
 rtl/md5_crack_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/md5_crack_ctrl.sv
// md5_crack_ctrl: drives LANES hash cores over disjoint decimal ranges and reports the first digest match.
module md5_crack_ctrl #(
  parameter int LANES = 2,
  parameter int DIGITS = 8,
  parameter int CLK_PER_MS = 100000,
  parameter int TIME_DIGITS = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [127:0]            target,
  output logic [64*LANES-1:0]     core_msg,
  output logic [LANES-1:0]        core_new,
  input  logic [LANES-1:0]        core_valid,
  input  logic [128*LANES-1:0]    core_digest,
  output logic                    busy,
  output logic                    found,
  output logic                    exhausted,
  output logic [8*DIGITS-1:0]     passwd,
  output logic [8*DIGITS-1:0]     progress,
  output logic [4*TIME_DIGITS-1:0] elapsed_ms
);
  localparam int W = 4*DIGITS;
  localparam int TW = 4*TIME_DIGITS;
  localparam int TB = $clog2(CLK_PER_MS+1);
  localparam int SPAN = 10**DIGITS / LANES;
  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int j = 0; j < DIGITS; j++) begin
      r[4*j +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  // off=0 gives each lane's first candidate, off=1 its last
  function automatic logic [LANES-1:0][W-1:0] lane_bcd(int off);
    logic [LANES-1:0][W-1:0] r;
    for (int l = 0; l < LANES; l++) r[l] = to_bcd((l+off)*SPAN - off);
    return r;
  endfunction
  function automatic logic [W-1:0] cnt_inc(logic [W-1:0] v);
    logic [W-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int j = 0; j < DIGITS; j++)
      if (c) begin
        c = r[4*j +: 4] == 4'd9;
        r[4*j +: 4] = c ? 4'd0 : r[4*j +: 4] + 4'd1;
      end
    return r;
  endfunction
  function automatic logic [TW-1:0] el_inc(logic [TW-1:0] v);
    logic [TW-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int j = 0; j < TIME_DIGITS; j++)
      if (c) begin
        c = r[4*j +: 4] == 4'd9;
        r[4*j +: 4] = c ? 4'd0 : r[4*j +: 4] + 4'd1;
      end
    return r;
  endfunction
  function automatic logic [8*DIGITS-1:0] ascii(logic [W-1:0] v);
    logic [8*DIGITS-1:0] r;
    for (int j = 0; j < DIGITS; j++) r[8*j +: 8] = {4'h3, v[4*j +: 4]};
    return r;
  endfunction
  localparam logic [LANES-1:0][W-1:0] BASE = lane_bcd(0);
  localparam logic [LANES-1:0][W-1:0] LAST = lane_bcd(1);
  localparam logic [TW-1:0] ALL9 = {TIME_DIGITS{4'h9}};
  typedef enum logic [1:0] {IDLE, RUN, FOUND, EXHAUSTED} state_t;
  state_t state, nxt;
  logic [127:0] tgt;
  logic [LANES-1:0][W-1:0] cnt;
  logic [LANES-1:0] done, act, hit, fin;
  logic [W-1:0] pw, win;
  logic [TB-1:0] tick;
  logic wrap, go, all_done;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  // lane loop runs high to low so the lowest matching lane wins
  always_comb begin
    act = state == RUN ? core_valid & ~done : '0;
    hit = '0;
    fin = '0;
    win = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      hit[i] = act[i] && core_digest[128*i +: 128] == tgt;
      fin[i] = act[i] && cnt[i] == LAST[i];
      if (hit[i]) win = cnt[i];
    end
    all_done = &(done | fin);
    go = start && !abort && state != RUN;
    wrap = tick == TB'(CLK_PER_MS-1);
    nxt = abort ? IDLE :
          go ? RUN :
          state == RUN && |hit ? FOUND :
          state == RUN && all_done ? EXHAUSTED : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      core_new <= '0;
      cnt <= '0;
      done <= '0;
      tick <= '0;
      elapsed_ms <= '0;
      pw <= '0;
      tgt <= '0;
    end else begin
      core_new <= '0;
      if (go) begin
        tgt <= target;
        cnt <= BASE;
        done <= '0;
        tick <= '0;
        elapsed_ms <= '0;
        pw <= '0;
        core_new <= '1;
      end else if (state == RUN) begin
        tick <= wrap ? '0 : tick + 1'b1;
        if (wrap && elapsed_ms != ALL9) elapsed_ms <= el_inc(elapsed_ms);
        if (!abort && |hit) pw <= win;
        else if (!abort)
          for (int i = 0; i < LANES; i++)
            if (act[i]) begin
              if (fin[i]) done[i] <= 1'b1;
              else begin
                cnt[i] <= cnt_inc(cnt[i]);
                core_new[i] <= 1'b1;
              end
            end
      end
    end
  always_comb begin
    core_msg = {LANES{ {8{8'h30}} }};
    for (int i = 0; i < LANES; i++) core_msg[64*i +: 8*DIGITS] = ascii(cnt[i]);
  end
  assign busy = state == RUN;
  assign found = state == FOUND;
  assign exhausted = state == EXHAUSTED;
  assign passwd = ascii(pw);
  assign progress = ascii(cnt[0]);
endmodule
